// File: rtl/motores_pkg.sv
// -----------------------------------------------------------------------------
// motores_pkg
//   Shared definitions for the dual-axis stepper driver.
//   - Direction code constants used by the upstream movement controller.
//   - Full-step and half-step coil tables, packed with phase 0 in the LSBs.
//   - Phase index width and coil lookup, both selected by the build macro
//     HALF_STEP_EN (defined: 8-phase half stepping, undefined: 4-phase full
//     stepping).
// -----------------------------------------------------------------------------
package motores_pkg;

  // Direction codes. 2'b10 is not named; it is treated as stop.
  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b11;

  // Coil tables, entry n lives at bits [4n+3:4n].
  // Full step : 1100, 0110, 0011, 1001
  localparam logic [15:0] FULL_STEP_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
  // Half step : 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001
  localparam logic [31:0] HALF_STEP_TABLE = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                             4'b0110, 4'b0100, 4'b1100, 4'b1000};

`ifdef HALF_STEP_EN
  localparam int PHASE_W = 3;
`else
  localparam int PHASE_W = 2;
`endif

  typedef logic [PHASE_W-1:0] phase_t;

  // Coil pattern for a given phase index of the active table.
  function automatic logic [3:0] coil_pattern(input phase_t phase);
`ifdef HALF_STEP_EN
    return HALF_STEP_TABLE[{phase, 2'b00} +: 4];
`else
    return FULL_STEP_TABLE[{phase, 2'b00} +: 4];
`endif
  endfunction

endpackage : motores_pkg

// File: rtl/eje_paso.sv
// -----------------------------------------------------------------------------
// eje_paso
//   One stepper axis: phase index, 16-bit position, idle counter, soft limit
//   flag and registered coil pattern. Everything advances only on `tick`.
//
// Ports
//   clk     in   1  system clock
//   rst_n   in   1  asynchronous active-low reset
//   tick    in   1  one-cycle step strobe from the shared prescaler
//   dir     in   2  direction code (00/10 stop, 01 CW, 11 CCW)
//   coils   out  4  registered coil drive pattern
//   pos     out 16  registered position count
//   limit   out  1  high while pos equals POS_MIN or POS_MAX
//
// Build option: HALF_STEP_EN (via motores_pkg) selects the 8-phase table.
// -----------------------------------------------------------------------------
module eje_paso
  import motores_pkg::*;
#(
  parameter logic [15:0] POS_MIN    = 16'd0,
  parameter logic [15:0] POS_MAX    = 16'd3600,
  parameter logic [15:0] POS_HOME   = 16'd0,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [1:0]  dir,
  output logic [3:0]  coils,
  output logic [15:0] pos,
  output logic        limit
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS);

  phase_t      phase_q, phase_d;
  logic [15:0] pos_q,   pos_d;
  logic [7:0]  idle_q,  idle_d;
  logic [3:0]  coils_q, coils_d;
  logic        step_cw;
  logic        step_ccw;

  always_comb begin
    // Limit checks come before the update, so pos never wraps.
    step_cw  = tick && (dir == DIR_CW)  && (pos_q < POS_MAX);
    step_ccw = tick && (dir == DIR_CCW) && (pos_q > POS_MIN);

    phase_d = phase_q;
    pos_d   = pos_q;
    idle_d  = idle_q;
    coils_d = coils_q;

    if (step_cw) begin
      phase_d = phase_q + phase_t'(1);
      pos_d   = pos_q + 16'd1;
      idle_d  = 8'd0;
      coils_d = coil_pattern(phase_d);
    end else if (step_ccw) begin
      phase_d = phase_q - phase_t'(1);
      pos_d   = pos_q - 16'd1;
      idle_d  = 8'd0;
      coils_d = coil_pattern(phase_d);
    end else if (tick) begin
      // Idle tick: count up to HOLD_TICKS, then release the coils.
      // The phase index is kept so the next step continues the sequence.
      if (idle_q < HOLD_LAST) begin
        idle_d = idle_q + 8'd1;
      end
      if (idle_d == HOLD_LAST) begin
        coils_d = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      pos_q   <= POS_HOME;
      idle_q  <= 8'd0;
      coils_q <= 4'b0000;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
      idle_q  <= idle_d;
      coils_q <= coils_d;
    end
  end

  assign coils = coils_q;
  assign pos   = pos_q;
  assign limit = (pos_q == POS_MIN) || (pos_q == POS_MAX);

endmodule : eje_paso

// File: rtl/driver_motores_paso.sv
// -----------------------------------------------------------------------------
// driver_motores_paso
//   Dual-axis stepper driver. A shared prescaler produces a one-cycle tick
//   every STEP_DIV clocks; the teta (vertical) and fi (horizontal) axes each
//   sample their direction code on that tick and sequence their coils.
//
// Ports
//   clk           in   1  system clock
//   rst_n         in   1  asynchronous active-low reset
//   s_out_teta    in   2  teta direction code
//   s_out_fi      in   2  fi direction code
//   bobinas_teta  out  4  teta coil pattern (registered)
//   bobinas_fi    out  4  fi coil pattern (registered)
//   teta_actual   out 16  teta position count
//   fi_actual     out 16  fi position count
//   limite_teta   out  1  teta at POS_MIN or POS_MAX
//   limite_fi     out  1  fi at POS_MIN or POS_MAX
//
// Build option: define HALF_STEP_EN for 8-phase half stepping; the default
// build uses the 4-phase full-step table.
// -----------------------------------------------------------------------------
module driver_motores_paso
  import motores_pkg::*;
#(
  parameter int unsigned STEP_DIV   = 50000,
  parameter logic [15:0] POS_MIN    = 16'd0,
  parameter logic [15:0] POS_MAX    = 16'd3600,
  parameter logic [15:0] POS_HOME   = 16'd0,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  s_out_teta,
  input  logic [1:0]  s_out_fi,
  output logic [3:0]  bobinas_teta,
  output logic [3:0]  bobinas_fi,
  output logic [15:0] teta_actual,
  output logic [15:0] fi_actual,
  output logic        limite_teta,
  output logic        limite_fi
);

  localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);

  // ---------------------------------------------------------------------------
  // Shared step-rate prescaler: 0..STEP_DIV-1, tick on the last count.
  // ---------------------------------------------------------------------------
  logic [15:0] presc_q, presc_d;
  logic        tick;

  always_comb begin
    tick    = (presc_q == DIV_LAST);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Axis array: index 0 = teta, index 1 = fi.
  // ---------------------------------------------------------------------------
  logic [1:0]  dir_arr   [2];
  logic [3:0]  coils_arr [2];
  logic [15:0] pos_arr   [2];
  logic        limit_arr [2];

  assign dir_arr[0] = s_out_teta;
  assign dir_arr[1] = s_out_fi;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_eje
      eje_paso #(
        .POS_MIN    (POS_MIN),
        .POS_MAX    (POS_MAX),
        .POS_HOME   (POS_HOME),
        .HOLD_TICKS (HOLD_TICKS)
      ) u_eje (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .dir   (dir_arr[gi]),
        .coils (coils_arr[gi]),
        .pos   (pos_arr[gi]),
        .limit (limit_arr[gi])
      );
    end
  endgenerate

  assign bobinas_teta = coils_arr[0];
  assign teta_actual  = pos_arr[0];
  assign limite_teta  = limit_arr[0];
  assign bobinas_fi   = coils_arr[1];
  assign fi_actual    = pos_arr[1];
  assign limite_fi    = limit_arr[1];

endmodule : driver_motores_paso

// File: tb/tb_driver_motores_paso.sv
// -----------------------------------------------------------------------------
// tb_driver_motores_paso
//   Scoreboard bench: stimulus pushes the expected post-tick outputs tagged
//   with the tick number; a monitor pops and compares on every update edge.
//   STEP_DIV=4, HOLD_TICKS=3, POS_HOME=0, POS_MAX=3600.
// -----------------------------------------------------------------------------
module tb_driver_motores_paso;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  s_out_teta = 2'b00;
  logic [1:0]  s_out_fi = 2'b00;
  logic [3:0]  bobinas_teta, bobinas_fi;
  logic [15:0] teta_actual, fi_actual;
  logic        limite_teta, limite_fi;

  driver_motores_paso #(
    .STEP_DIV   (4),
    .POS_MIN    (16'd0),
    .POS_MAX    (16'd3600),
    .POS_HOME   (16'd0),
    .HOLD_TICKS (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_out_teta   (s_out_teta),
    .s_out_fi     (s_out_fi),
    .bobinas_teta (bobinas_teta),
    .bobinas_fi   (bobinas_fi),
    .teta_actual  (teta_actual),
    .fi_actual    (fi_actual),
    .limite_teta  (limite_teta),
    .limite_fi    (limite_fi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tick;
    string       name;
    logic [3:0]  bt;
    logic [15:0] ta;
    logic        lt;
    logic [3:0]  bf;
    logic [15:0] fa;
    logic        lf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  // Clock edges since reset release; updates land on multiples of 4.
  int unsigned edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Coil pattern after a net number of steps from phase 0.
  function automatic logic [3:0] pat(input int ph);
    logic [3:0] tbl [8];
    int n;
    int m;
`ifdef HALF_STEP_EN
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    n = 8;
`else
    tbl = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    n = 4;
`endif
    m = ph % n;
    if (m < 0) m = m + n;
    return tbl[m];
  endfunction

  task automatic compare(input string name,
                         input logic [3:0] bt, input logic [15:0] ta, input logic lt,
                         input logic [3:0] bf, input logic [15:0] fa, input logic lf);
    total++;
    if (bobinas_teta !== bt || teta_actual !== ta || limite_teta !== lt ||
        bobinas_fi !== bf || fi_actual !== fa || limite_fi !== lf) begin
      bad++;
      $display("FAIL %s: got bt=%b ta=%0d lt=%b bf=%b fa=%0d lf=%b, want bt=%b ta=%0d lt=%b bf=%b fa=%0d lf=%b",
               name, bobinas_teta, teta_actual, limite_teta, bobinas_fi, fi_actual, limite_fi,
               bt, ta, lt, bf, fa, lf);
    end else begin
      $display("ok   %s: bt=%b ta=%0d lt=%b bf=%b fa=%0d lf=%b",
               name, bobinas_teta, teta_actual, limite_teta, bobinas_fi, fi_actual, limite_fi);
    end
  endtask

  // Monitor: on each update edge, compare against the entry for this tick.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && edges != 0 && (edges % 4) == 0) begin
      while (sb_q.size() > 0 && sb_q[0].tick < edges / 4) begin
        e = sb_q.pop_front();
        total++;
        bad++;
        $display("FAIL %s: tick %0d never checked, now at tick %0d", e.name, e.tick, edges / 4);
      end
      if (sb_q.size() > 0 && sb_q[0].tick == edges / 4) begin
        e = sb_q.pop_front();
        compare(e.name, e.bt, e.ta, e.lt, e.bf, e.fa, e.lf);
      end
    end
  end

  // Wait for the update edge of a given tick, bounded.
  task automatic wait_update(input int unsigned tick_no);
    int guard = 0;
    while (edges < tick_no * 4 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      total++;
      bad++;
      $display("FAIL wait_update: edges=%0d want %0d", edges, tick_no * 4);
    end
  endtask

  task automatic step(input logic [1:0] dt, input logic [1:0] df, input string name,
                      input logic [3:0] bt, input logic [15:0] ta, input logic lt,
                      input logic [3:0] bf, input logic [15:0] fa, input logic lf);
    exp_t e;
    int unsigned t;
    s_out_teta = dt;
    s_out_fi   = df;
    t = edges / 4 + 1;
    e.tick = t; e.name = name;
    e.bt = bt; e.ta = ta; e.lt = lt; e.bf = bf; e.fa = fa; e.lf = lf;
    sb_q.push_back(e);
    wait_update(t);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    exp_t e;

    // Reset state
    repeat (3) @(negedge clk);
    compare("reset", 4'b0000, 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);

    // Release with teta CW; nothing moves before the 4th edge
    s_out_teta = 2'b01;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    compare("pre_first_tick", 4'b0000, 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);

    // teta CW x5
    for (int i = 1; i <= 5; i++)
      step(2'b01, 2'b00, $sformatf("teta_cw_%0d", i), pat(i), 16'(i), 1'b0, 4'b0000, 16'd0, 1'b1);

    // teta CCW back to 0
    for (int i = 1; i <= 5; i++)
      step(2'b11, 2'b00, $sformatf("teta_ccw_%0d", i), pat(5 - i), 16'(5 - i), (i == 5),
           4'b0000, 16'd0, 1'b1);

    // CCW at POS_MIN: idle, hold twice, release on the third
    step(2'b11, 2'b00, "ccw_at_min_1", pat(0), 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);
    step(2'b11, 2'b00, "ccw_at_min_2", pat(0), 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);
    step(2'b11, 2'b00, "ccw_at_min_3", 4'b0000, 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);
    step(2'b11, 2'b00, "ccw_at_min_4", 4'b0000, 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);
    step(2'b01, 2'b00, "reenergise", pat(1), 16'd1, 1'b0, 4'b0000, 16'd0, 1'b1);

    // Toggle 01 -> 11 (on the tick) -> 01: one CCW step only
    s_out_teta = 2'b01;
    t = edges / 4 + 1;
    e.tick = t; e.name = "toggle_ccw";
    e.bt = pat(0); e.ta = 16'd0; e.lt = 1'b1; e.bf = 4'b0000; e.fa = 16'd0; e.lf = 1'b1;
    sb_q.push_back(e);
    while (edges < t * 4 - 1) @(negedge clk);
    s_out_teta = 2'b11;
    wait_update(t);
    s_out_teta = 2'b01;
    repeat (2) @(negedge clk);
    step(2'b00, 2'b00, "toggle_after", pat(0), 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);

    // fi run up to POS_MAX-1 unchecked, then check the limit region
    s_out_teta = 2'b00;
    s_out_fi   = 2'b01;
    for (int i = 0; i < 3598; i++) wait_update(edges / 4 + 1);
    step(2'b00, 2'b01, "fi_3599", 4'b0000, 16'd0, 1'b1, pat(3599), 16'd3599, 1'b0);
    step(2'b00, 2'b01, "fi_max", 4'b0000, 16'd0, 1'b1, pat(3600), 16'd3600, 1'b1);
    step(2'b00, 2'b01, "fi_at_max_1", 4'b0000, 16'd0, 1'b1, pat(3600), 16'd3600, 1'b1);
    step(2'b00, 2'b01, "fi_at_max_2", 4'b0000, 16'd0, 1'b1, pat(3600), 16'd3600, 1'b1);
    step(2'b00, 2'b01, "fi_at_max_3", 4'b0000, 16'd0, 1'b1, 4'b0000, 16'd3600, 1'b1);

    // Both axes moving, then reset mid-interval
    step(2'b01, 2'b11, "both_1", pat(1), 16'd1, 1'b0, pat(3599), 16'd3599, 1'b0);
    step(2'b01, 2'b11, "both_2", pat(2), 16'd2, 1'b0, pat(3598), 16'd3598, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("reset_mid", 4'b0000, 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);
    @(negedge clk);
    s_out_teta = 2'b01;
    s_out_fi   = 2'b00;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    compare("restart_pre_tick", 4'b0000, 16'd0, 1'b1, 4'b0000, 16'd0, 1'b1);
    step(2'b01, 2'b00, "restart_cw", pat(1), 16'd1, 1'b0, 4'b0000, 16'd0, 1'b1);

    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_driver_motores_paso
